hwpe_ctrl_uloop_pipe: RTL and testbench
=======================================

// Module: hwpe_ctrl_uloop_pipe
// PURPOSE
//  Next-generation micro-loop address engine for HWPE controllers.
//  Walks up to NB_LOOPS nested loops. Runs a per-loop microcode block (MOV/ADD/SUB/NOP)
//  on NB_REG offset registers, and pushes one {offs, idx, last} snapshot per iteration
//  into an output FIFO (FIFO_DEPTH deep) drained by a valid/ready handshake.
//  Sits between the controller register file and the streamer address generators.
// PARAMETERS
//  NB_LOOPS   6   nested loops (loop 0 innermost)
//  CODE_LEN   32  microcode entries
//  NB_REG     4   writable offset registers
//  NB_RO_REG  28  read-only operand registers
//  REG_WIDTH  32  register/offset width
//  CNT_WIDTH  16  loop index/range width
//  FIFO_DEPTH 2   snapshot prefetch depth (>=1)
// PORTS
//  clk_i              in   1                     clock
//  rst_ni             in   1                     async reset, active-low
//  test_mode_i        in   1                     test mode (no functional effect)
//  clear_i            in   1                     sync soft clear
//  start_i            in   1                     start a run (honoured in IDLE only)
//  cfg_i              in   uloop_cfg_t           loops[].addr/nb_ops, range[], code[]; stable while busy_o
//  registers_read_i   in   NB_RO_REG*REG_WIDTH   read-only operands
//  out_valid_o        out  1                     snapshot available
//  out_ready_i        in   1                     consumer accepts snapshot
//  out_offs_o         out  NB_REG*REG_WIDTH      offset registers of snapshot
//  out_idx_o          out  NB_LOOPS*CNT_WIDTH    loop indices of snapshot
//  out_last_o         out  1                     final snapshot of run
//  busy_o             out  1                     run in progress
//  done_o             out  1                     1-cycle pulse on last snapshot popped
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, regs/idx/FIFO cleared. clear_i does the same sync,
//   priority over everything, also mid-run. Mid-run clear: no done_o, FIFO flushed.
//  FSM IDLE -> PUSH (start_i; regs=0, idx=0) -> {EXEC | DONE} ; EXEC -> PUSH ; DONE -> IDLE.
//  PUSH: write snapshot {regs, idx, last} to FIFO. Stall in PUSH while FIFO full.
//   After the write, select L = lowest loop with idx[L] < range[L]-1.
//   No such L: last=1 on this write, go DONE.
//   Else: idx[L]++, idx[j<L]=0, addr=loops[L].addr, go EXEC (PUSH directly if nb_ops[L]==0).
//   last is computed combinationally from the same test, so it is set on the correct write.
//  EXEC: one op/cycle, addr..addr+nb_ops[L]-1, then PUSH.
//   Op {a<NB_REG, b<NB_REG+NB_RO_REG, op}; operand space = regs then registers_read_i.
//   MOV R[a]=S[b]; ADD R[a]+=S[b]; SUB R[a]-=S[b]; NOP. Modulo 2^REG_WIDTH wrap, no saturation.
//   Code addr wraps mod CODE_LEN.
//  DONE: wait for last snapshot popped (valid&ready&last) -> done_o pulse, busy_o=0, IDLE same edge.
//  busy_o: 1 from cycle after start_i until the done_o cycle inclusive. start_i when not IDLE ignored.
//  Range 0 treated as 1. Snapshots per run = product of ranges.
//  Latency: start_i @t -> PUSH @t+1 -> out_valid_o @t+2.
//   Per snapshot: nb_ops[L]+1 cycles when not back-pressured.
//  FIFO: registered outputs, first-word visible; simultaneous push+pop when full is NOT allowed
//   (PUSH stalls on full). out_* hold stable while out_valid_o & ~out_ready_i.
// STRUCTURE
//  hwpe_ctrl_package: uloop_op_e {MOV,ADD,SUB,NOP}, uloop_code_t, uloop_loop_t, uloop_cfg_t,
//   uloop_snap_t, default constants ULOOP_*.
//  Sub-module hwpe_ctrl_uloop_snap_fifo (depth FIFO_DEPTH, data uloop_snap_t, clear input).
//  Top holds FSM, index counters, microcode ALU, register file.
// TESTING
//  1 range={3,1..}, loop0 code ADD r0+=ro0, ro0=4, ready=1 -> r0 0,4,8; idx0 0,1,2;
//    last on 3rd; one done_o.
//  2 range={2,3}, loop0 ADD r0+=ro0(1); loop1 ADD r1+=ro1(10), MOV r0=r1 ->
//    r0 0,1,10,11,20,21; (idx1,idx0) 00,01,10,11,20,21.
//  3 Scenario 2 with ready=0 for 20 cycles, FIFO_DEPTH=2 -> FSM held in PUSH after 2 writes;
//    same 6 snapshots in order after release, none lost or duplicated.
//  4 loop0 SUB r0-=ro0, ro0=1, range={2} -> r0 0x00000000 then 0xFFFFFFFF.
//  5 clear_i at 3rd snapshot of scenario 2 -> next cycle out_valid_o=0, busy_o=0, no done_o;
//    new start_i reproduces full sequence.
//  6 all ranges 1 -> single snapshot (zeros, last=1); start_i pulsed while busy ignored.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_pipe_pkg.sv
// Shared types and default sizes for the micro-loop address engine.
// Included first; every other uloop file imports it.
package hwpe_ctrl_package;

   localparam int ULOOP_NB_LOOPS   = 6;
   localparam int ULOOP_CODE_LEN   = 32;
   localparam int ULOOP_NB_REG     = 4;
   localparam int ULOOP_NB_RO_REG  = 28;
   localparam int ULOOP_REG_WIDTH  = 32;
   localparam int ULOOP_CNT_WIDTH  = 16;
   localparam int ULOOP_FIFO_DEPTH = 2;

   localparam int ULOOP_ADDR_W = $clog2(ULOOP_CODE_LEN);
   localparam int ULOOP_OPA_W  = $clog2(ULOOP_NB_REG);
   localparam int ULOOP_OPB_W  = $clog2(ULOOP_NB_REG + ULOOP_NB_RO_REG);
   localparam int ULOOP_LSEL_W = $clog2(ULOOP_NB_LOOPS);

   typedef logic [ULOOP_CNT_WIDTH-1:0] uloop_cnt_t;
   typedef logic [ULOOP_REG_WIDTH-1:0] uloop_reg_t;

   typedef enum logic [1:0] {
      ULOOP_MOV,
      ULOOP_ADD,
      ULOOP_SUB,
      ULOOP_NOP
   } uloop_op_e;

   typedef struct packed {
      logic [ULOOP_OPA_W-1:0] a;
      logic [ULOOP_OPB_W-1:0] b;
      uloop_op_e              op;
   } uloop_code_t;

   typedef struct packed {
      logic [ULOOP_ADDR_W-1:0] addr;
      logic [ULOOP_ADDR_W:0]   nb_ops;
   } uloop_loop_t;

   typedef struct packed {
      uloop_loop_t [ULOOP_NB_LOOPS-1:0] loops;
      uloop_cnt_t  [ULOOP_NB_LOOPS-1:0] range;
      uloop_code_t [ULOOP_CODE_LEN-1:0] code;
   } uloop_cfg_t;

   typedef struct packed {
      uloop_reg_t [ULOOP_NB_REG-1:0]   offs;
      uloop_cnt_t [ULOOP_NB_LOOPS-1:0] idx;
      logic                            last;
   } uloop_snap_t;

   // A range of 0 behaves like 1: the loop runs exactly once.
   function automatic uloop_cnt_t uloop_last_idx(input uloop_cnt_t r);
      return (r == '0) ? '0 : r - 1'b1;
   endfunction

endpackage

// File: rtl/hwpe_ctrl_uloop_snap_fifo.sv
// Snapshot FIFO: shift-register storage, head always at entry 0
// so the first word is visible straight from a register.
module hwpe_ctrl_uloop_snap_fifo
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        push_i,
   input  uloop_snap_t data_i,
   output logic        full_o,
   input  logic        pop_i,
   output logic        valid_o,
   output uloop_snap_t data_o
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] cnt_q, cnt_d, wr;
   uloop_snap_t [DEPTH-1:0] mem_q, mem_d;
   logic do_pop, do_push;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign valid_o = (cnt_q != '0);
   assign data_o  = mem_q[0];
   assign do_pop  = pop_i & valid_o;
   assign do_push = push_i & ~full_o;
   assign wr      = do_pop ? cnt_q - 1'b1 : cnt_q;

   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      if (do_pop) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++)
            mem_d[i] = mem_q[i+1];
         cnt_d = cnt_d - 1'b1;
      end
      if (do_push) begin
         for (int i = 0; i < int'(DEPTH); i++)
            if (CW'(i) == wr) mem_d[i] = data_i;
         cnt_d = cnt_d + 1'b1;
      end
      if (clear_i) begin
         mem_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hwpe_ctrl_uloop_pipe.sv
// Micro-loop address engine: nested loop walker, microcode ALU on
// offset registers, snapshots pushed into a small prefetch FIFO.
module hwpe_ctrl_uloop_pipe
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned FIFO_DEPTH = ULOOP_FIFO_DEPTH
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       test_mode_i,
   input  logic                                       clear_i,
   input  logic                                       start_i,
   input  uloop_cfg_t                                 cfg_i,
   input  logic [ULOOP_NB_RO_REG*ULOOP_REG_WIDTH-1:0] registers_read_i,
   output logic                                       out_valid_o,
   input  logic                                       out_ready_i,
   output logic [ULOOP_NB_REG*ULOOP_REG_WIDTH-1:0]    out_offs_o,
   output logic [ULOOP_NB_LOOPS*ULOOP_CNT_WIDTH-1:0]  out_idx_o,
   output logic                                       out_last_o,
   output logic                                       busy_o,
   output logic                                       done_o
);

   typedef enum logic [1:0] {IDLE, PUSH, EXEC, DONE} state_e;

   localparam logic [ULOOP_ADDR_W:0] OPS_ONE = (ULOOP_ADDR_W+1)'(1);

   state_e state_q, state_d;
   uloop_reg_t [ULOOP_NB_REG-1:0]   regs_q, regs_d;
   uloop_cnt_t [ULOOP_NB_LOOPS-1:0] idx_q, idx_d;
   logic [ULOOP_ADDR_W-1:0] addr_q, addr_d;
   logic [ULOOP_ADDR_W:0]   opcnt_q, opcnt_d;

   uloop_reg_t [ULOOP_NB_REG+ULOOP_NB_RO_REG-1:0] opnd;
   uloop_code_t code;
   uloop_reg_t  alu_res;
   logic [ULOOP_LSEL_W-1:0] sel;
   logic found, push, done;
   logic fifo_full;
   uloop_snap_t snap_in, snap_out;

   assign opnd = {registers_read_i, regs_q};
   assign code = cfg_i.code[addr_q];

   always_comb begin
      unique case (code.op)
         ULOOP_MOV: alu_res = opnd[code.b];
         ULOOP_ADD: alu_res = regs_q[code.a] + opnd[code.b];
         ULOOP_SUB: alu_res = regs_q[code.a] - opnd[code.b];
         default:   alu_res = regs_q[code.a];
      endcase
   end

   // Scan downwards so the innermost loop with room left wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int l = ULOOP_NB_LOOPS - 1; l >= 0; l--) begin
         if (idx_q[l] < uloop_last_idx(cfg_i.range[l])) begin
            found = 1'b1;
            sel   = ULOOP_LSEL_W'(l);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      regs_d  = regs_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      opcnt_d = opcnt_q;
      push    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               regs_d  = '0;
               idx_d   = '0;
               state_d = PUSH;
            end
         end
         PUSH: begin
            if (!fifo_full) begin
               push = 1'b1;
               if (!found) begin
                  state_d = DONE;
               end else begin
                  for (int l = 0; l < ULOOP_NB_LOOPS; l++)
                     if (l < int'(sel)) idx_d[l] = '0;
                  idx_d[sel] = idx_q[sel] + 1'b1;
                  addr_d  = cfg_i.loops[sel].addr;
                  opcnt_d = cfg_i.loops[sel].nb_ops;
                  state_d = (cfg_i.loops[sel].nb_ops == '0) ? PUSH : EXEC;
               end
            end
         end
         EXEC: begin
            regs_d[code.a] = alu_res;
            addr_d  = addr_q + 1'b1;
            opcnt_d = opcnt_q - 1'b1;
            if (opcnt_q == OPS_ONE) state_d = PUSH;
         end
         DONE: begin
            if (out_valid_o && out_ready_i && out_last_o) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         regs_d  = '0;
         idx_d   = '0;
         addr_d  = '0;
         opcnt_d = '0;
         push    = 1'b0;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         regs_q  <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         opcnt_q <= '0;
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         opcnt_q <= opcnt_d;
      end
   end

   assign snap_in = '{offs: regs_q, idx: idx_q, last: ~found};

   hwpe_ctrl_uloop_snap_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push),
      .data_i  (snap_in),
      .full_o  (fifo_full),
      .pop_i   (out_ready_i),
      .valid_o (out_valid_o),
      .data_o  (snap_out)
   );

   assign out_offs_o = snap_out.offs;
   assign out_idx_o  = snap_out.idx;
   assign out_last_o = snap_out.last;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_pipe.sv
// Directed bench for the micro-loop engine: snapshot sequences,
// back-pressure, wrap-around, soft clear and single-shot runs.
module tb_hwpe_ctrl_uloop_pipe;
   import hwpe_ctrl_package::*;

   logic clk_i = 1'b0;
   logic rst_ni, test_mode_i, clear_i, start_i, out_ready_i;
   uloop_cfg_t cfg;
   logic [ULOOP_NB_RO_REG*32-1:0] ro;
   logic out_valid_o, out_last_o, busy_o, done_o;
   logic [ULOOP_NB_REG*32-1:0] out_offs_o;
   logic [ULOOP_NB_LOOPS*16-1:0] out_idx_o;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] got_r0[$];
   logic [31:0] got_ix[$];
   logic        got_last[$];
   int done_cnt, first_cyc;
   bit stall_ok;

   always #5 clk_i = ~clk_i;

   hwpe_ctrl_uloop_pipe dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .test_mode_i      (test_mode_i),
      .clear_i          (clear_i),
      .start_i          (start_i),
      .cfg_i            (cfg),
      .registers_read_i (ro),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .out_offs_o       (out_offs_o),
      .out_idx_o        (out_idx_o),
      .out_last_o       (out_last_o),
      .busy_o           (busy_o),
      .done_o           (done_o)
   );

   task automatic run(input int stall, input int clear_at,
                      input bit pulse, output bit tmo);
      bit fin;
      got_r0.delete(); got_ix.delete(); got_last.delete();
      done_cnt = 0; first_cyc = -1; stall_ok = 0; fin = 0;
      @(negedge clk_i); start_i = 1; out_ready_i = 0;
      @(negedge clk_i); start_i = 0;
      for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
         @(negedge clk_i);
         clear_i = 0;
         start_i = pulse && (cyc == 1);
         out_ready_i = (cyc > stall);
         #1;
         if (cyc == 15)
            stall_ok = out_valid_o && busy_o && out_offs_o[31:0] == 0
                       && out_idx_o == 0;
         if (out_valid_o && first_cyc < 0) first_cyc = cyc;
         if (out_valid_o && out_ready_i) begin
            got_r0.push_back(out_offs_o[31:0]);
            got_ix.push_back(out_idx_o[31:0]);
            got_last.push_back(out_last_o);
            if (clear_at != 0 && got_r0.size() == clear_at) begin
               clear_i = 1; fin = 1;
            end
         end
         if (done_o) begin done_cnt++; fin = 1; end
      end
      start_i = 0;
      tmo = !fin;
   endtask

   task automatic cfg_nested();
      cfg = '0;
      for (int l = 0; l < ULOOP_NB_LOOPS; l++) cfg.range[l] = 16'd1;
      cfg.range[0] = 16'd2;
      cfg.range[1] = 16'd3;
      cfg.loops[0] = '{addr: 5'd0, nb_ops: 6'd1};
      cfg.loops[1] = '{addr: 5'd4, nb_ops: 6'd2};
      cfg.code[0] = '{a: 2'd0, b: 5'd4, op: ULOOP_ADD};
      cfg.code[4] = '{a: 2'd1, b: 5'd5, op: ULOOP_ADD};
      cfg.code[5] = '{a: 2'd0, b: 5'd1, op: ULOOP_MOV};
      ro = '0;
      ro[31:0]  = 32'd1;
      ro[63:32] = 32'd10;
   endtask

   task automatic test_reset();
      rst_ni = 0; clear_i = 0; start_i = 0; out_ready_i = 0;
      test_mode_i = 0; cfg = '0; ro = '0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1;
      @(negedge clk_i);
      n_chk++;
      if (out_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid_o);
      end
      n_chk++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy_done got %b%b exp 00", busy_o, done_o);
      end
      n_chk++;
      if (out_offs_o !== '0 || out_idx_o !== '0 || out_last_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_data got %h/%h/%b exp 0", out_offs_o, out_idx_o, out_last_o);
      end
   endtask

   task automatic test_single_loop();
      bit tmo;
      logic [31:0] er [3] = '{32'd0, 32'd4, 32'd8};
      cfg = '0;
      for (int l = 0; l < ULOOP_NB_LOOPS; l++) cfg.range[l] = 16'd1;
      cfg.range[0] = 16'd3;
      cfg.loops[0] = '{addr: 5'd0, nb_ops: 6'd1};
      cfg.code[0] = '{a: 2'd0, b: 5'd4, op: ULOOP_ADD};
      ro = '0; ro[31:0] = 32'd4;
      run(0, 0, 0, tmo);
      n_chk++;
      if (tmo || got_r0.size() != 3) begin
         n_fail++; $display("FAIL s1_count got %0d exp 3 (tmo %b)", got_r0.size(), tmo);
      end
      n_chk++;
      if (first_cyc != 1) begin
         n_fail++; $display("FAIL s1_latency got %0d exp 1", first_cyc);
      end
      for (int i = 0; i < got_r0.size() && i < 3; i++) begin
         n_chk++;
         if (got_r0[i] !== er[i] || got_ix[i] !== 32'(i)
             || got_last[i] !== (i == 2)) begin
            n_fail++;
            $display("FAIL s1_snap%0d got r0=%h ix=%h l=%b exp r0=%h ix=%h l=%b",
                     i, got_r0[i], got_ix[i], got_last[i], er[i], i, i == 2);
         end
      end
      n_chk++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL s1_done got %0d exp 1", done_cnt);
      end
      @(negedge clk_i); #1;
      n_chk++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL s1_idle got busy=%b done=%b exp 0 0", busy_o, done_o);
      end
   endtask

   task automatic test_nested(input string nm, input int stall);
      bit tmo;
      logic [31:0] er [6] = '{32'd0, 32'd1, 32'd10, 32'd11, 32'd20, 32'd21};
      logic [31:0] ei [6] = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000,
                              32'h0001_0001, 32'h0002_0000, 32'h0002_0001};
      cfg_nested();
      run(stall, 0, 0, tmo);
      n_chk++;
      if (tmo || got_r0.size() != 6) begin
         n_fail++; $display("FAIL %s_count got %0d exp 6 (tmo %b)", nm, got_r0.size(), tmo);
      end
      for (int i = 0; i < got_r0.size() && i < 6; i++) begin
         n_chk++;
         if (got_r0[i] !== er[i] || got_ix[i] !== ei[i]
             || got_last[i] !== (i == 5)) begin
            n_fail++;
            $display("FAIL %s_snap%0d got r0=%h ix=%h l=%b exp r0=%h ix=%h l=%b",
                     nm, i, got_r0[i], got_ix[i], got_last[i], er[i], ei[i], i == 5);
         end
      end
      n_chk++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL %s_done got %0d exp 1", nm, done_cnt);
      end
      @(negedge clk_i); #1;
   endtask

   task automatic test_backpressure();
      test_nested("s3", 20);
      n_chk++;
      if (stall_ok !== 1'b1) begin
         n_fail++; $display("FAIL s3_hold got %b exp 1", stall_ok);
      end
   endtask

   task automatic test_sub_wrap();
      bit tmo;
      cfg = '0;
      cfg.range[0] = 16'd2;
      cfg.loops[0] = '{addr: 5'd0, nb_ops: 6'd1};
      cfg.code[0] = '{a: 2'd0, b: 5'd4, op: ULOOP_SUB};
      ro = '0; ro[31:0] = 32'd1;
      run(0, 0, 0, tmo);
      n_chk++;
      if (tmo || got_r0.size() != 2) begin
         n_fail++; $display("FAIL s4_count got %0d exp 2 (tmo %b)", got_r0.size(), tmo);
      end else begin
         n_chk++;
         if (got_r0[0] !== 32'h0 || got_r0[1] !== 32'hFFFF_FFFF
             || got_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL s4_wrap got %h %h l=%b exp 00000000 ffffffff l=1",
                     got_r0[0], got_r0[1], got_last[1]);
         end
      end
      @(negedge clk_i); #1;
   endtask

   task automatic test_clear();
      bit tmo;
      cfg_nested();
      run(0, 3, 0, tmo);
      n_chk++;
      if (tmo || got_r0.size() != 3 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL s5_pre got n=%0d done=%0d exp n=3 done=0", got_r0.size(), done_cnt);
      end
      @(negedge clk_i); clear_i = 0; #1;
      n_chk++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL s5_after got v=%b b=%b d=%b exp 0 0 0", out_valid_o, busy_o, done_o);
      end
      test_nested("s5rerun", 0);
   endtask

   task automatic test_single_shot();
      bit tmo;
      cfg = '0;
      for (int l = 0; l < ULOOP_NB_LOOPS; l++) cfg.range[l] = 16'd1;
      cfg.code[0] = '{a: 2'd0, b: 5'd4, op: ULOOP_ADD};
      ro = '0; ro[31:0] = 32'd7;
      run(4, 0, 1, tmo);
      n_chk++;
      if (tmo || got_r0.size() != 1) begin
         n_fail++; $display("FAIL s6_count got %0d exp 1 (tmo %b)", got_r0.size(), tmo);
      end else begin
         n_chk++;
         if (got_r0[0] !== 32'h0 || got_ix[0] !== 32'h0 || got_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL s6_snap got r0=%h ix=%h l=%b exp 0 0 1", got_r0[0], got_ix[0], got_last[0]);
         end
      end
      n_chk++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL s6_done got %0d exp 1", done_cnt);
      end
      @(negedge clk_i); #1;
      n_chk++;
      if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL s6_ignored_start got busy=%b v=%b exp 0 0", busy_o, out_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_loop();
      test_nested("s2", 0);
      test_backpressure();
      test_sub_wrap();
      test_clear();
      test_single_shot();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
